meta_info_streamer: RTL and testbench
=====================================

META_INFO_STREAMER -- requirements
Module: meta_info_streamer

Interface
REQ-001 SHALL have parameter CLKS_PER_BIT, default 4, clock cycles per UART bit; legal range 2..65535.
REQ-002 SHALL have parameter ROM_LAT, default 2, cycles from a rom_idx/rom_chr change to a valid rom_data; legal range 1..15.
REQ-003 SHALL have port clock  input  1  sole clock; all state updates on its rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port start  input  1  one-cycle request to stream a project message.
REQ-006 SHALL have port proj_idx  input  6  project index, sampled when start is accepted.
REQ-007 SHALL have port rom_idx  output  6  project index driven to the meta-info ROM.
REQ-008 SHALL have port rom_chr  output  6  character index driven to the meta-info ROM.
REQ-009 SHALL have port rom_data  input  8  ASCII character returned by the ROM; 0x00 terminates the message.
REQ-010 SHALL have port busy  output  1  high from accepted start until done.
REQ-011 SHALL have port done  output  1  one-cycle pulse when a message has been fully transmitted.
REQ-012 SHALL have port uart_tx  output  1  8N1 serial output, idle high.

Function
REQ-013 States SHALL be IDLE, FETCH, CHECK, TX_START, TX_DATA, TX_STOP, FINISH.
REQ-014 In IDLE, start SHALL latch proj_idx into rom_idx, clear rom_chr to 0, set busy, enter FETCH next cycle.
REQ-015 start while busy SHALL be ignored; proj_idx changes while busy SHALL not affect rom_idx.
REQ-016 FETCH SHALL hold rom_idx/rom_chr stable for exactly ROM_LAT cycles, then enter CHECK and register rom_data into a character register.
REQ-017 CHECK: character 0x00 SHALL go to FINISH without a frame; otherwise SHALL go to TX_START.
REQ-018 Frame: uart_tx low CLKS_PER_BIT cycles (TX_START), 8 data bits LSB first CLKS_PER_BIT cycles each (TX_DATA), high CLKS_PER_BIT cycles (TX_STOP); 10*CLKS_PER_BIT cycles total.
REQ-019 After TX_STOP, if rom_chr == 62 SHALL go to FINISH (max 63 characters); else rom_chr increments by 1 and SHALL return to FETCH.
REQ-020 rom_chr SHALL never exceed 62 and never wrap.
REQ-021 FINISH SHALL last one cycle: done high, busy low from next cycle, return to IDLE; start in the FINISH cycle ignored.
REQ-022 uart_tx SHALL be high in every state except TX_START and TX_DATA.
REQ-023 Bit counter width SHALL be $clog2(CLKS_PER_BIT); bit index 3 bits.

Reset
REQ-024 While reset high: state IDLE, rom_idx 0, rom_chr 0, busy 0, done 0, uart_tx 1, all counters 0; effective immediately, including mid-frame.
REQ-025 First start SHALL be accepted on the first rising clock edge after reset deasserts.

Configuration
REQ-026 Macro META_STREAM_CRLF_EN defined: after the message (terminator or 63 chars) SHALL send frames 0x0D then 0x0A before FINISH, also for empty messages.
REQ-027 Macro META_STREAM_CRLF_EN undefined: no trailing frames; CRLF logic absent.

Structure
REQ-028 Package meta_info_pkg SHALL hold the state enum type, MSG_MAX_CHR = 62, CHR_CR = 8'h0D, CHR_LF = 8'h0A.
REQ-029 Sub-module meta_uart_tx (8N1 serializer, CLKS_PER_BIT parameter, valid/ready load) SHALL hold TX_START/TX_DATA/TX_STOP timing; streamer owns FETCH/CHECK/FINISH sequencing.

Verification
REQ-030 ROM model idx 5 = "AB\0", CLKS_PER_BIT=4, ROM_LAT=2, start proj_idx=5 -> frames 0x41, 0x42, each 40 cycles, then one done pulse, busy low.
REQ-031 Empty message (rom_data 0 at chr 0) -> no uart_tx low, done exactly ROM_LAT+2 cycles after the start cycle.
REQ-032 63-char message without terminator -> exactly 63 frames, rom_chr max observed 62, done once.
REQ-033 reset asserted during TX_DATA of 2nd char -> uart_tx 1, busy 0, rom_chr 0 same cycle; new start streams from chr 0.
REQ-034 start pulsed with proj_idx=9 during busy streaming idx 5 -> ignored, rom_idx stays 5, single done.
REQ-035 META_STREAM_CRLF_EN defined, "AB\0" -> frames 0x41, 0x42, 0x0D, 0x0A then done; empty message -> 0x0D, 0x0A.

Source files
------------

// File: rtl/meta_info_pkg.sv
// Shared state types and character constants for the meta-info UART streamer.
package meta_info_pkg;

   typedef enum logic [2:0] {
      IDLE     = 3'd0,
      FETCH    = 3'd1,
      CHECK    = 3'd2,
      TX_START = 3'd3,
      TX_DATA  = 3'd4,
      TX_STOP  = 3'd5,
      FINISH   = 3'd6
   } stream_state_t;

   typedef enum logic [1:0] {
      UTX_IDLE  = 2'd0,
      UTX_START = 2'd1,
      UTX_DATA  = 2'd2,
      UTX_STOP  = 2'd3
   } utx_state_t;

   localparam logic [5:0] MSG_MAX_CHR = 6'd62;
   localparam logic [7:0] CHR_NUL     = 8'h00;
   localparam logic [7:0] CHR_CR      = 8'h0D;
   localparam logic [7:0] CHR_LF      = 8'h0A;

endpackage

// File: rtl/meta_uart_tx.sv
// 8N1 serializer: loads a byte on valid && ready, drives start, 8 data bits LSB first, stop.
// The *_last strobes mark the final cycle of each frame segment for the streamer's sequencing.
module meta_uart_tx
   import meta_info_pkg::*;
#(
   parameter int CLKS_PER_BIT = 4
)
(
   input  logic       clock,
   input  logic       reset,
   input  logic       valid,
   input  logic [7:0] data,
   output logic       ready,
   output logic       start_last,
   output logic       data_last,
   output logic       stop_last,
   output logic       tx
);

   localparam int            CW       = $clog2(CLKS_PER_BIT);
   localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);
   localparam logic [CW-1:0] CNT_ZERO = CW'(0);
   localparam logic [CW-1:0] CNT_ONE  = CW'(1);

   utx_state_t    state_r;
   logic [CW-1:0] cnt_r;
   logic [2:0]    bit_r;
   logic [7:0]    shift_r;
   logic          tx_r;

   assign ready      = (state_r == UTX_IDLE);
   assign start_last = (state_r == UTX_START) && (cnt_r == CNT_LAST);
   assign data_last  = (state_r == UTX_DATA) && (cnt_r == CNT_LAST) && (bit_r == 3'd7);
   assign stop_last  = (state_r == UTX_STOP) && (cnt_r == CNT_LAST);
   assign tx         = tx_r;

   // Frame sequencer; tx_r is updated on the same edge as the segment change so the line is glitch-free.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_r <= UTX_IDLE;
         cnt_r   <= CNT_ZERO;
         bit_r   <= 3'd0;
         shift_r <= 8'h00;
         tx_r    <= 1'b1;
      end else begin
         case (state_r)
            UTX_IDLE: begin
               if (valid) begin
                  state_r <= UTX_START;
                  shift_r <= data;
                  cnt_r   <= CNT_ZERO;
                  bit_r   <= 3'd0;
                  tx_r    <= 1'b0;
               end
            end
            UTX_START: begin
               if (cnt_r == CNT_LAST) begin
                  cnt_r   <= CNT_ZERO;
                  state_r <= UTX_DATA;
                  tx_r    <= shift_r[0];
               end else begin
                  cnt_r <= cnt_r + CNT_ONE;
               end
            end
            UTX_DATA: begin
               if (cnt_r == CNT_LAST) begin
                  cnt_r <= CNT_ZERO;
                  if (bit_r == 3'd7) begin
                     state_r <= UTX_STOP;
                     bit_r   <= 3'd0;
                     tx_r    <= 1'b1;
                  end else begin
                     bit_r   <= bit_r + 3'd1;
                     shift_r <= {1'b0, shift_r[7:1]};
                     tx_r    <= shift_r[1];
                  end
               end else begin
                  cnt_r <= cnt_r + CNT_ONE;
               end
            end
            UTX_STOP: begin
               if (cnt_r == CNT_LAST) begin
                  cnt_r   <= CNT_ZERO;
                  state_r <= UTX_IDLE;
               end else begin
                  cnt_r <= cnt_r + CNT_ONE;
               end
            end
            default: begin
               state_r <= UTX_IDLE;
               cnt_r   <= CNT_ZERO;
               bit_r   <= 3'd0;
               tx_r    <= 1'b1;
            end
         endcase
      end
   end

endmodule

// File: rtl/meta_info_streamer.sv
// Streams a NUL-terminated (max 63 chars) meta-info ROM message out over an 8N1 UART.
// Optional trailing CR/LF frames are enabled by defining META_STREAM_CRLF_EN.
module meta_info_streamer
   import meta_info_pkg::*;
#(
   parameter int CLKS_PER_BIT = 4,
   parameter int ROM_LAT      = 2
)
(
   input  logic       clock,
   input  logic       reset,
   input  logic       start,
   input  logic [5:0] proj_idx,
   output logic [5:0] rom_idx,
   output logic [5:0] rom_chr,
   input  logic [7:0] rom_data,
   output logic       busy,
   output logic       done,
   output logic       uart_tx
);

   localparam logic [3:0] FETCH_LAST = 4'(ROM_LAT - 1);

   stream_state_t state_r;
   logic [3:0]    fetch_cnt_r;
   logic [7:0]    char_r;
   logic [5:0]    rom_idx_r;
   logic [5:0]    rom_chr_r;
   logic          busy_r;
   logic          done_r;
   logic          tx_valid_s;
   logic          tx_ready_s;
   logic          start_last_s;
   logic          data_last_s;
   logic          stop_last_s;
`ifdef META_STREAM_CRLF_EN
   // 0: message body, 1: CR frame in flight, 2: LF frame in flight
   logic [1:0]    trail_r;
`endif

   assign tx_valid_s = (state_r == CHECK) && (char_r != CHR_NUL);
   assign rom_idx    = rom_idx_r;
   assign rom_chr    = rom_chr_r;
   assign busy       = busy_r;
   assign done       = done_r;

   meta_uart_tx #(
      .CLKS_PER_BIT (CLKS_PER_BIT)
   ) u_uart_tx (
      .clock      (clock),
      .reset      (reset),
      .valid      (tx_valid_s),
      .data       (char_r),
      .ready      (tx_ready_s),
      .start_last (start_last_s),
      .data_last  (data_last_s),
      .stop_last  (stop_last_s),
      .tx         (uart_tx)
   );

   // Message sequencer: fetch, check for terminator, hand frames to the serializer, finish.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_r     <= IDLE;
         fetch_cnt_r <= 4'd0;
         char_r      <= 8'h00;
         rom_idx_r   <= 6'd0;
         rom_chr_r   <= 6'd0;
         busy_r      <= 1'b0;
         done_r      <= 1'b0;
`ifdef META_STREAM_CRLF_EN
         trail_r     <= 2'd0;
`endif
      end else begin
         done_r <= 1'b0;
         case (state_r)
            IDLE: begin
               if (start) begin
                  rom_idx_r   <= proj_idx;
                  rom_chr_r   <= 6'd0;
                  busy_r      <= 1'b1;
                  fetch_cnt_r <= 4'd0;
                  state_r     <= FETCH;
`ifdef META_STREAM_CRLF_EN
                  trail_r     <= 2'd0;
`endif
               end
            end
            FETCH: begin
               if (fetch_cnt_r == FETCH_LAST) begin
                  fetch_cnt_r <= 4'd0;
                  char_r      <= rom_data;
                  state_r     <= CHECK;
               end else begin
                  fetch_cnt_r <= fetch_cnt_r + 4'd1;
               end
            end
            CHECK: begin
               if (char_r == CHR_NUL) begin
`ifdef META_STREAM_CRLF_EN
                  // Re-enter CHECK with CR so the trailer reuses the normal frame path
                  char_r  <= CHR_CR;
                  trail_r <= 2'd1;
`else
                  done_r  <= 1'b1;
                  state_r <= FINISH;
`endif
               end else if (tx_ready_s) begin
                  state_r <= TX_START;
               end
            end
            TX_START: begin
               if (start_last_s) begin
                  state_r <= TX_DATA;
               end
            end
            TX_DATA: begin
               if (data_last_s) begin
                  state_r <= TX_STOP;
               end
            end
            TX_STOP: begin
               if (stop_last_s) begin
`ifdef META_STREAM_CRLF_EN
                  if (trail_r == 2'd1) begin
                     char_r  <= CHR_LF;
                     trail_r <= 2'd2;
                     state_r <= CHECK;
                  end else if (trail_r == 2'd2) begin
                     done_r  <= 1'b1;
                     state_r <= FINISH;
                  end else if (rom_chr_r == MSG_MAX_CHR) begin
                     char_r  <= CHR_CR;
                     trail_r <= 2'd1;
                     state_r <= CHECK;
                  end else begin
                     rom_chr_r <= rom_chr_r + 6'd1;
                     state_r   <= FETCH;
                  end
`else
                  if (rom_chr_r == MSG_MAX_CHR) begin
                     done_r  <= 1'b1;
                     state_r <= FINISH;
                  end else begin
                     rom_chr_r <= rom_chr_r + 6'd1;
                     state_r   <= FETCH;
                  end
`endif
               end
            end
            FINISH: begin
               busy_r  <= 1'b0;
               state_r <= IDLE;
            end
            default: begin
               busy_r  <= 1'b0;
               state_r <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_meta_info_streamer.sv
// Randomized bench for meta_info_streamer: a ROM model, a UART line decoder and a message-level
// reference (expected bytes, frame start times, done time) derived from the ROM contents.
module tb_meta_info_streamer;
   import meta_info_pkg::*;

   localparam int CPB    = 4;
   localparam int LAT    = 2;
   localparam int P      = LAT + 1 + 10 * CPB;
   localparam int BUDGET = 4000;

   logic       clock = 1'b0;
   logic       reset;
   logic       start;
   logic [5:0] proj_idx;
   logic [5:0] rom_idx;
   logic [5:0] rom_chr;
   logic [7:0] rom_data;
   logic       busy;
   logic       done;
   logic       uart_tx;

   logic [7:0] rom_mem [0:63][0:63];
   logic [5:0] a_idx_d;
   logic [5:0] a_chr_d;
   int         cyc = 0;
   int         n_cmp = 0;
   int         n_err = 0;
   logic [7:0] rx_q[$];
   int         rx_t0_q[$];
   int         rx_ferr = 0;
   int         rx_on = 0;
   int         rx_t = 0;
   logic [7:0] rx_byte = 8'h00;
   int         t0r;

   meta_info_streamer #(.CLKS_PER_BIT(CPB), .ROM_LAT(LAT)) dut (
      .clock    (clock),
      .reset    (reset),
      .start    (start),
      .proj_idx (proj_idx),
      .rom_idx  (rom_idx),
      .rom_chr  (rom_chr),
      .rom_data (rom_data),
      .busy     (busy),
      .done     (done),
      .uart_tx  (uart_tx)
   );

   always #5 clock = ~clock;
   always @(posedge clock) cyc <= cyc + 1;

   // ROM: LAT-1 address registers ahead of a combinational lookup gives data valid LAT cycles after a change
   always @(posedge clock) begin
      a_idx_d <= rom_idx;
      a_chr_d <= rom_chr;
   end
   assign rom_data = rom_mem[a_idx_d][a_chr_d];

   // Line decoder: mid-bit sampling relative to the first low cycle seen
   always @(negedge clock) begin
      if (reset) begin
         rx_on = 0;
         rx_t  = 0;
      end else if (rx_on == 0) begin
         if (uart_tx == 1'b0) begin
            rx_on = 1;
            rx_t  = 0;
            rx_t0_q.push_back(cyc);
         end
      end else begin
         rx_t++;
         if (rx_t == CPB / 2 && uart_tx != 1'b0) rx_ferr++;
         if (rx_t >= CPB + CPB / 2 && rx_t < 9 * CPB && ((rx_t - CPB / 2) % CPB) == 0)
            rx_byte[3'((rx_t - CPB / 2) / CPB - 1)] = uart_tx;
         if (rx_t == 9 * CPB + CPB / 2 && uart_tx != 1'b1) rx_ferr++;
         if (rx_t == 10 * CPB - 1) begin
            rx_q.push_back(rx_byte);
            rx_on = 0;
         end
      end
   end

   task automatic check_val(input string tag, input int obs, input int exp);
      n_cmp++;
      if (obs != exp) begin
         n_err++;
         $display("FAIL %s: observed %0d (0x%0h) expected %0d (0x%0h)", tag, obs, obs, exp, exp);
      end
   endtask

   function automatic int msg_len(input int idx);
      int n = 0;
      while (n < 63 && rom_mem[idx][n] != 8'h00) n++;
      return n;
   endfunction

   // Streams one message; poke adds an ignored start mid-message and one in the FINISH cycle
   task automatic run_msg(input int idx, input bit poke);
      logic [7:0] exp_q[$];
      int n_msg, t0, t_done, n_done, max_chr, idx_bad, busy_bad, base, base_t, ferr0;
      n_msg = msg_len(idx);
      for (int i = 0; i < n_msg; i++) exp_q.push_back(rom_mem[idx][i]);
`ifdef META_STREAM_CRLF_EN
      exp_q.push_back(CHR_CR);
      exp_q.push_back(CHR_LF);
`endif
      base = rx_q.size(); base_t = rx_t0_q.size(); ferr0 = rx_ferr;
      t_done = -1; n_done = 0; max_chr = 0; idx_bad = 0; busy_bad = 0;
      @(negedge clock);
      start = 1'b1; proj_idx = 6'(idx); t0 = cyc;
      for (int k = 0; k < BUDGET; k++) begin
         @(negedge clock);
         start = 1'b0; proj_idx = 6'($urandom);
         if (poke && cyc - t0 == 60) begin
            start = 1'b1; proj_idx = 6'd9;
         end
         if (busy && rom_idx != 6'(idx)) idx_bad++;
         if (int'(rom_chr) > max_chr) max_chr = int'(rom_chr);
         if ((t_done < 0 && !busy) || (t_done >= 0 && busy)) busy_bad++;
         if (done) begin
            n_done++;
            t_done = cyc;
            if (poke) start = 1'b1;
         end
         if (t_done >= 0 && cyc - t_done >= 4) break;
      end
      start = 1'b0;
      check_val("done_count", n_done, 1);
`ifndef META_STREAM_CRLF_EN
      check_val("done_time", t_done - t0, (n_msg == 63) ? 63 * P + 1 : n_msg * P + LAT + 2);
`endif
      check_val("busy_window", busy_bad, 0);
      check_val("idx_hold", idx_bad, 0);
      check_val("chr_max", max_chr, (n_msg == 63) ? 62 : n_msg);
      check_val("frame_count", rx_q.size() - base, exp_q.size());
      check_val("framing", rx_ferr - ferr0, 0);
      for (int i = 0; i < exp_q.size() && base + i < rx_q.size(); i++)
         check_val($sformatf("byte%0d", i), int'(rx_q[base + i]), int'(exp_q[i]));
      for (int i = 0; i < n_msg && base_t + i < rx_t0_q.size(); i++)
         check_val($sformatf("frame%0d_start", i), rx_t0_q[base_t + i] - t0, LAT + 2 + i * P);
   endtask

   initial begin
      reset = 1'b1; start = 1'b0; proj_idx = 6'd0;
      for (int i = 0; i < 64; i++)
         for (int j = 0; j < 64; j++) rom_mem[i][j] = 8'h00;
      rom_mem[5][0] = 8'h41; rom_mem[5][1] = 8'h42;
      rom_mem[9][0] = 8'h5A; rom_mem[9][1] = 8'h59;
      rom_mem[7][1] = 8'h55;
      for (int j = 0; j < 64; j++) rom_mem[12][j] = 8'($urandom_range(1, 255));

      repeat (3) @(negedge clock);
      check_val("rst_busy", int'(busy), 0);
      check_val("rst_done", int'(done), 0);
      check_val("rst_tx", int'(uart_tx), 1);
      check_val("rst_idx", int'(rom_idx), 0);
      check_val("rst_chr", int'(rom_chr), 0);
      @(posedge clock); #1 reset = 1'b0;

      run_msg(5, 1'b1);
      run_msg(7, 1'b0);
      run_msg(12, 1'b0);

      for (int r = 0; r < 6; r++) begin
         int idx, len;
         idx = int'($urandom_range(16, 63));
         len = int'($urandom_range(0, 6));
         for (int j = 0; j < len; j++) rom_mem[idx][j] = 8'($urandom_range(1, 255));
         rom_mem[idx][len] = 8'h00;
         repeat ($urandom_range(0, 3)) @(negedge clock);
         run_msg(idx, r[0]);
      end

      for (int i = 0; i < 4; i++) rom_mem[5][i] = 8'($urandom_range(1, 255));
      rom_mem[5][4] = 8'h00;
      @(negedge clock);
      start = 1'b1; proj_idx = 6'd5; t0r = cyc;
      @(negedge clock);
      start = 1'b0;
      while (cyc - t0r < LAT + 2 + P + CPB + 6) @(negedge clock);
      check_val("pre_reset_busy", int'(busy), 1);
      check_val("pre_reset_chr", int'(rom_chr), 1);
      #1 reset = 1'b1;
      #1;
      check_val("midrst_tx", int'(uart_tx), 1);
      check_val("midrst_busy", int'(busy), 0);
      check_val("midrst_chr", int'(rom_chr), 0);
      check_val("midrst_idx", int'(rom_idx), 0);
      check_val("midrst_done", int'(done), 0);
      repeat (3) @(negedge clock);
      @(posedge clock); #1 reset = 1'b0;
      run_msg(5, 1'b0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
